bus_arbiter: RTL
================

# bus_arbiter

Two-master arbiter for the serial system bus. It decides which master port (master 1 or master 2) drives the shared bus, using round-robin tie-breaking. It enforces a configurable hold timeout and inserts one idle turnaround cycle between ownerships. It sits between the two master ports and the bus mux. Its `msel` output steers the master-side bus signals to the slaves, and each grant line enables the corresponding master's transmit/receive ports.

## Interface
- `TIMEOUT`, 250: maximum consecutive cycles a master may hold a grant. 0 disables the timeout.
- `CNT_LEN`, 16: width of the hold counter. Must satisfy `TIMEOUT < 2**CNT_LEN`.

- `clk` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m1_request` in 1: master 1 requests or holds the bus. Held high for the whole transaction; dropped to release.
- `m2_request` in 1: same as `m1_request`, for master 2.
- `m1_grant` out 1: master 1 owns the bus.
- `m2_grant` out 1: master 2 owns the bus.
- `msel` out 1: bus mux select. 0 = master 1, 1 = master 2.
- `bus_busy` out 1: high while any grant is active or during turnaround.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the timeout.
- `arb_state` out 3: current state, for debug.

## Operation
- States: `IDLE`=0, `GRANT_M1`=1, `GRANT_M2`=2, `RELEASE`=3. Any other state value goes to `IDLE` on the next clock.
- Internal registers:
  - `last`: the master granted most recently. Reset value is master 2, so master 1 wins the first tie.
  - `count` (CNT_LEN bits): hold counter.
- `IDLE`:
  - Only `m1_request` high: go to `GRANT_M1`.
  - Only `m2_request` high: go to `GRANT_M2`.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in `IDLE`.
  - On entering a grant state: `count`←0, `last`←the granted master, `msel`←the granted master.
- `GRANT_Mx`:
  - Owner's request low: go to `RELEASE`, no timeout pulse.
  - Owner's request high, `TIMEOUT`≠0 and `count`==`TIMEOUT`-1: go to `RELEASE` and pulse `timeout`.
  - Otherwise: `count`←`count`+1 and stay in `GRANT_Mx`.
  - The other master's request is ignored while a grant is active. No preemption.
- `RELEASE`: both grants low, `bus_busy` high. Always goes to `IDLE` on the next clock. Requests are not sampled here.
- Timed-out master:
  - It must drop its request on seeing `timeout`.
  - If it keeps requesting, it is handled normally in `IDLE`. Round-robin still favours the other master when both request.
- Output definitions:
  - `m1_grant` is high exactly when the state is `GRANT_M1`; `m2_grant` exactly when it is `GRANT_M2`. Both are registered.
  - `bus_busy` is high when the state is not `IDLE`.
  - `msel` holds its last value in `IDLE` and `RELEASE`.
- Simultaneous events:
  - Owner drops its request in the same cycle the timeout condition is met: treated as a normal release, no `timeout` pulse.
  - Both masters request in the same `IDLE` cycle: resolved by `last` as above.

## Timing
- Reset values: state `IDLE`, `m1_grant`=0, `m2_grant`=0, `msel`=0, `bus_busy`=0, `timeout`=0, `count`=0, `last`=master 2.
- Reset asserted mid-transaction: grants drop immediately (asynchronous), with no `RELEASE` cycle.
- Grant latency:
  - Request sampled high in `IDLE` at edge n; grant is high from edge n+1.
  - Minimum request-to-grant delay is 1 cycle.
- Release latency:
  - Request sampled low at edge n in a grant state; grant falls at edge n+1 (`RELEASE`).
  - The next grant can rise no earlier than edge n+3.
- Timeout timing:
  - A grant is high for at most `TIMEOUT` cycles.
  - `timeout` is high for exactly the one cycle following revocation, i.e. in `RELEASE`.
- `count` does not wrap within a grant when `TIMEOUT`≠0. With `TIMEOUT`=0 it wraps modulo 2^`CNT_LEN` with no effect.
- Grants are never both high in any cycle. There is always at least one cycle with no grant between different (or the same) owners.

## Test plan
- Reset, then pulse `m1_request` high for 5 cycles -> `m1_grant` high for 5 cycles starting 1 cycle after the request; `msel`=0; `bus_busy` high for 6 cycles; `m2_grant` stays 0.
- Both requests rise in the same cycle after reset; each drops 4 cycles after it is granted -> M1 is granted first; one `RELEASE` cycle follows; then M2 is granted; grants never overlap and `msel` goes 0→1.
- M2 holds its request during an M1 transaction of 10 cycles -> `m2_grant` rises exactly 2 cycles after `m1_grant` falls; M1 re-requesting during that window does not win.
- `TIMEOUT`=8, M1 holds its request for 20 cycles -> `m1_grant` is high for exactly 8 cycles; `timeout` pulses once; with the request still high, M1 is re-granted after `RELEASE`+`IDLE`, unless M2 is requesting, in which case M2 wins.
- `TIMEOUT`=8, M1 drops its request in the cycle `count`==7 -> normal release, `timeout` stays 0.
- Assert `reset` asynchronously while `m2_grant`=1 -> `m2_grant`, `bus_busy` and `msel` go to 0 before the next clock edge; after `reset` deasserts with both requesting, M1 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with hold timeout and one turnaround cycle.
// The mux select, grant lines, busy flag and timeout pulse are all registered
// so the bus mux and master ports see glitch-free controls.
module bus_arbiter #(
    parameter int TIMEOUT = 250,
    parameter int CNT_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m2_request,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       msel,
    output logic       bus_busy,
    output logic       timeout,
    output logic [2:0] arb_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT_M1 = 3'd1,
        GRANT_M2 = 3'd2,
        RELEASE  = 3'd3
    } state_t;

    // A zero TIMEOUT disables revocation; the counter then just free-runs.
    localparam logic               TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_LEN-1:0] LIMIT = CNT_LEN'(TIMEOUT - 1);

    state_t             state_q;
    logic               last_q;      // 0 = master 1 granted last, 1 = master 2
    logic [CNT_LEN-1:0] count_q;
    logic               m1_grant_q;
    logic               m2_grant_q;
    logic               msel_q;
    logic               busy_q;
    logic               timeout_q;

    // Request of whichever master currently owns the bus.
    logic owner_req;
    assign owner_req = (state_q == GRANT_M1) ? m1_request : m2_request;

    // Arbitration FSM with all bus controls registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            count_q    <= '0;
            m1_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
            msel_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Master 1 wins unless master 2 also asks and master 1 went last.
                    if (m1_request && (!m2_request || last_q)) begin
                        state_q    <= GRANT_M1;
                        m1_grant_q <= 1'b1;
                        last_q     <= 1'b0;
                        msel_q     <= 1'b0;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                    end else if (m2_request) begin
                        state_q    <= GRANT_M2;
                        m2_grant_q <= 1'b1;
                        last_q     <= 1'b1;
                        msel_q     <= 1'b1;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                GRANT_M1, GRANT_M2: begin
                    // A voluntary drop takes priority over a coincident timeout.
                    if (!owner_req) begin
                        state_q    <= RELEASE;
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                    end else if (TO_EN && (count_q == LIMIT)) begin
                        state_q    <= RELEASE;
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        timeout_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + CNT_LEN'(1);
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    m1_grant_q <= 1'b0;
                    m2_grant_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign m1_grant  = m1_grant_q;
    assign m2_grant  = m2_grant_q;
    assign msel      = msel_q;
    assign bus_busy  = busy_q;
    assign timeout   = timeout_q;
    assign arb_state = state_q;

endmodule
